rtc_calendar_alarm: RTL

//  Parametrised successor to the century clock datapath. It keeps hh:mm:ss and dd/mm/yyyy with full Gregorian leap rules.

---
 rtl/rtc_pkg.sv | 60 ++++++
 rtl/rtc_calendar_alarm_prescaler.sv | 51 +++++
 rtl/rtc_calendar_alarm.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// rtc_pkg: shared field widths, packed time/date records, reset constants
// and the calendar helpers used by the RTC datapath.
//   is_leap(year)               Gregorian leap rule
//   days_in_month(month, year)  28..31
//   time_valid(t)               hh<=23, mm<=59, ss<=59
//   bin2bcd2(v)                 0..99   -> 2 BCD digits
//   bin2bcd4(v)                 0..9999 -> 4 BCD digits
package rtc_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;
    localparam int DAY_W  = 5;
    localparam int MON_W  = 4;
    localparam int YEAR_W = 14;

    localparam logic [YEAR_W-1:0] YEAR_MAX = 14'd9999;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  minute;
        logic [SEC_W-1:0]  second;
    } time_t;

    typedef struct packed {
        logic [YEAR_W-1:0] year;
        logic [MON_W-1:0]  month;
        logic [DAY_W-1:0]  day;
    } date_t;

    localparam time_t TIME_RESET = '{hour: '0, minute: '0, second: '0};

    function automatic logic is_leap(input logic [YEAR_W-1:0] y);
        return ((y % 14'd4 == 14'd0) && (y % 14'd100 != 14'd0)) ||
               (y % 14'd400 == 14'd0);
    endfunction

    function automatic logic [DAY_W-1:0] days_in_month(input logic [MON_W-1:0] m,
                                                       input logic [YEAR_W-1:0] y);
        case (m)
            4'd2:                      return is_leap(y) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
            default:                   return 5'd31;
        endcase
    endfunction

    function automatic logic time_valid(input time_t t);
        return (t.hour <= 5'd23) && (t.minute <= 6'd59) && (t.second <= 6'd59);
    endfunction

    function automatic logic [7:0] bin2bcd2(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    function automatic logic [15:0] bin2bcd4(input logic [YEAR_W-1:0] v);
        return {4'(v / 14'd1000), 4'((v / 14'd100) % 14'd10),
                4'((v / 14'd10) % 14'd10), 4'(v % 14'd10)};
    endfunction

endpackage

// File: rtl/rtc_calendar_alarm_prescaler.sv
// rtc_prescaler: clock-enable generator for the RTC.
//   clk, rst_n  system clock, async active-low reset
//   en          0 holds the prescaler in its restart state
//   sel_fast    1: period FAST_DIV cycles, 0: period F_IN cycles
//   clr         restart the period (time load)
//   tick        one-cycle pulse, once per period
// Implemented as a down-counter holding the cycles left before the tick;
// a restart reloads it so the next tick lands a full period later.
module rtc_prescaler #(
    parameter int F_IN     = 50_000_000,
    parameter int FAST_DIV = 5_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sel_fast,
    input  logic clr,
    output logic tick
);

    localparam int P_MAX = (F_IN > FAST_DIV) ? F_IN : FAST_DIV;
    localparam int CW    = (P_MAX > 2) ? $clog2(P_MAX) : 1;

    localparam logic [CW-1:0] LAST_SLOW = CW'(F_IN - 1);
    localparam logic [CW-1:0] LAST_FAST = CW'(FAST_DIV - 1);

    logic [CW-1:0] remain;
    logic [CW-1:0] reload;
    logic          sel_q;
    logic          restart;

    assign reload  = sel_fast ? LAST_FAST : LAST_SLOW;
    // A rate change is seen one cycle late through sel_q; that cycle restarts.
    assign restart = clr || !en || (sel_fast != sel_q);
    assign tick    = !restart && (remain == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain <= LAST_SLOW;
            sel_q  <= 1'b0;
        end else begin
            sel_q <= sel_fast;
            if (restart || remain == '0) begin
                remain <= reload;
            end else begin
                remain <= remain - CW'(1);
            end
        end
    end

endmodule

// File: rtl/rtc_calendar_alarm.sv
// rtc_calendar_alarm: hh:mm:ss dd/mm/yyyy real-time clock with Gregorian
// leap rules, validated atomic load and NUM_ALARMS sticky time-of-day alarms.
//   clk, rst_n          system clock, async active-low reset
//   en, sel_fast        run enable and tick-rate select
//   load/ld_time/ld_date   atomic time+date write (binary fields)
//   alm_wr/alm_idx/alm_time/alm_en   alarm channel write
//   alm_ack             per-channel flag clear
//   time_bcd, date_bcd  packed BCD view of the registered binary state
//   tick                pulse on every time advance
//   leap_year           current year is a leap year
//   load_err            pulse the cycle after a rejected load or alm_wr
//   alm_flag            sticky alarm-matched flags
module rtc_calendar_alarm
    import rtc_pkg::*;
#(
    parameter int F_IN       = 50_000_000,
    parameter int FAST_DIV   = 5_000,
    parameter int NUM_ALARMS = 2,
    parameter int YEAR_RESET = 2000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  sel_fast,
    input  logic                  load,
    input  logic [16:0]           ld_time,
    input  logic [22:0]           ld_date,
    input  logic                  alm_wr,
    input  logic [1:0]            alm_idx,
    input  logic [16:0]           alm_time,
    input  logic                  alm_en,
    input  logic [NUM_ALARMS-1:0] alm_ack,
    output logic [23:0]           time_bcd,
    output logic [31:0]           date_bcd,
    output logic                  tick,
    output logic                  leap_year,
    output logic                  load_err,
    output logic [NUM_ALARMS-1:0] alm_flag
);

    localparam date_t DATE_RESET = '{year: YEAR_W'(YEAR_RESET), month: 4'd1, day: 5'd1};

    time_t cur_t, nxt_t, ld_t, alm_t_in;
    date_t cur_d, nxt_d, ld_d;

    logic            ld_valid, ld_ok, alm_valid, alm_ok;
    logic [DAY_W-1:0] dim_cur;

    assign ld_t     = time_t'(ld_time);
    assign ld_d     = date_t'(ld_date);
    assign alm_t_in = time_t'(alm_time);

    rtc_prescaler #(
        .F_IN     (F_IN),
        .FAST_DIV (FAST_DIV)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sel_fast (sel_fast),
        .clr      (load),
        .tick     (tick)
    );

    // Day is checked against the month length of the year being loaded,
    // so 29/02 is accepted only together with a leap year.
    assign ld_valid = time_valid(ld_t) &&
                      (ld_d.year <= YEAR_MAX) &&
                      (ld_d.month >= 4'd1) && (ld_d.month <= 4'd12) &&
                      (ld_d.day >= 5'd1) &&
                      (ld_d.day <= days_in_month(ld_d.month, ld_d.year));
    assign ld_ok     = load && ld_valid;
    assign alm_valid = time_valid(alm_t_in) && (int'(alm_idx) < NUM_ALARMS);
    assign alm_ok    = alm_wr && alm_valid;

    assign dim_cur = days_in_month(cur_d.month, cur_d.year);

    // Full carry cascade from seconds to years for a single advance.
    always_comb begin
        nxt_t = cur_t;
        nxt_d = cur_d;
        if (cur_t.second != 6'd59) begin
            nxt_t.second = cur_t.second + 6'd1;
        end else begin
            nxt_t.second = '0;
            if (cur_t.minute != 6'd59) begin
                nxt_t.minute = cur_t.minute + 6'd1;
            end else begin
                nxt_t.minute = '0;
                if (cur_t.hour != 5'd23) begin
                    nxt_t.hour = cur_t.hour + 5'd1;
                end else begin
                    nxt_t.hour = '0;
                    if (cur_d.day < dim_cur) begin
                        nxt_d.day = cur_d.day + 5'd1;
                    end else begin
                        nxt_d.day = 5'd1;
                        if (cur_d.month != 4'd12) begin
                            nxt_d.month = cur_d.month + 4'd1;
                        end else begin
                            nxt_d.month = 4'd1;
                            nxt_d.year  = (cur_d.year == YEAR_MAX) ? '0 : cur_d.year + 14'd1;
                        end
                    end
                end
            end
        end
    end

    // The prescaler suppresses tick whenever load is high, so load always wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_t    <= TIME_RESET;
            cur_d    <= DATE_RESET;
            load_err <= 1'b0;
        end else begin
            load_err <= (load && !ld_valid) || (alm_wr && !alm_valid);
            if (ld_ok) begin
                cur_t <= ld_t;
                cur_d <= ld_d;
            end else if (tick) begin
                cur_t <= nxt_t;
                cur_d <= nxt_d;
            end
        end
    end

    for (genvar k = 0; k < NUM_ALARMS; k++) begin : g_alarm
        time_t alm_t_q;
        logic  alm_en_q;
        logic  flag_q;
        logic  hit;

        // Compared against the value being advanced into, so the flag rises
        // on the same edge as the matching time appears.
        assign hit         = tick && alm_en_q && (nxt_t == alm_t_q);
        assign alm_flag[k] = flag_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                alm_t_q  <= TIME_RESET;
                alm_en_q <= 1'b0;
                flag_q   <= 1'b0;
            end else begin
                if (alm_ok && (alm_idx == 2'(k))) begin
                    alm_t_q  <= alm_t_in;
                    alm_en_q <= alm_en;
                end
                if (hit) begin
                    flag_q <= 1'b1;
                end else if (alm_ack[k]) begin
                    flag_q <= 1'b0;
                end
            end
        end
    end

    assign time_bcd  = {bin2bcd2(7'(cur_t.hour)), bin2bcd2(7'(cur_t.minute)),
                        bin2bcd2(7'(cur_t.second))};
    assign date_bcd  = {bin2bcd2(7'(cur_d.day)), bin2bcd2(7'(cur_d.month)),
                        bin2bcd4(cur_d.year)};
    assign leap_year = is_leap(cur_d.year);

endmodule
